// File: rtl/tdc_pkg.sv
// Shared types and constants for the TDC thermometer decoder.
// Contents: clog2 helper, per-segment encoder result struct, default
// zero-run / guard constants.
package tdc_pkg;

    // Ceiling log2 for elaboration-time sizing (clog2(1) = 0).
    function automatic int unsigned clog2(input int unsigned v);
        int unsigned r;
        r = 0;
        while ((64'd1 << r) < 64'(v)) begin
            r = r + 1;
        end
        return r;
    endfunction

    localparam int unsigned DEF_ZERO_RUN = 4;
    localparam int unsigned DEF_GUARD    = 20;

    // The segment index field is sized for segments up to 256 taps.
    // The top checks that clog2(SEG_W) fits in this width.
    localparam int unsigned SEG_IDX_W = 8;

    // One segment's encoder result: any hit, highest local hit index,
    // and the hit count saturating at 2.
    typedef struct packed {
        logic                 any;
        logic [SEG_IDX_W-1:0] idx;
        logic [1:0]           cnt;
    } seg_result_t;

endpackage

// File: rtl/tdc_seg_encoder.sv
// One segment of the edge search: hit detect, last-priority encode and
// saturating hit count. Purely combinational; the top registers the result.
// Ports:
//   taps   in  SEG_W+ZERO_RUN  segment taps plus ZERO_RUN look-ahead taps
//   base   in  BITS_DECO       global index of taps[0]
//   seg_c  out seg_result_t    any / highest local hit index / count (sat 2)
module tdc_seg_encoder
    import tdc_pkg::*;
#(
    parameter int unsigned SEG_W     = 16,
    parameter int unsigned ZERO_RUN  = DEF_ZERO_RUN,
    parameter int unsigned BITS_DECO = 8,
    parameter int unsigned LIMIT     = 44
) (
    input  logic [SEG_W+ZERO_RUN-1:0] taps,
    input  logic [BITS_DECO-1:0]      base,
    output seg_result_t               seg_c
);

    // A tap hits when it is 1, the next ZERO_RUN taps are 0, and its global
    // index is below LIMIT. Scanning upward leaves the highest hit in idx.
    always_comb begin
        seg_c = '0;
        for (int j = 0; j < int'(SEG_W); j++) begin
            if (taps[j] && !(|taps[j+1 +: ZERO_RUN]) &&
                ((int'(base) + j) < int'(LIMIT))) begin
                seg_c.any = 1'b1;
                seg_c.idx = SEG_IDX_W'(j);
                if (seg_c.cnt != 2'd2) begin
                    seg_c.cnt = seg_c.cnt + 2'd1;
                end
            end
        end
    end

endmodule

// File: rtl/tdc_thermo_decoder.sv
// Pipelined thermometer-to-binary decoder for a TDC delay-line FF column.
// Finds the last tap holding a 1 followed by ZERO_RUN zeros (bubble
// tolerant) within taps 0..NUM_FF-GUARD-1 and reports index+1.
// Three register stages (column, segment results, outputs); latency 3 clk,
// one capture per cycle, no backpressure.
// Ports:
//   clk, rst_n     clock, synchronous active-low reset
//   in_valid       new capture on in_thermo this cycle
//   in_thermo      captured column, bit 0 = first tap
//   cfg_invert     invert column before search (falling-edge line)
//   out_valid      one-cycle strobe, out_* updated
//   out_bin        last qualifying index + 1; 0 = no edge
//   out_no_edge    no qualifying edge in the search range
//   out_multi      two or more qualifying edges
module tdc_thermo_decoder
    import tdc_pkg::*;
#(
    parameter int unsigned NUM_FF    = 64,
    parameter int unsigned BITS_DECO = 8,
    parameter int unsigned ZERO_RUN  = DEF_ZERO_RUN,
    parameter int unsigned GUARD     = DEF_GUARD,
    parameter int unsigned SEG_W     = 16
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 in_valid,
    input  logic [NUM_FF-1:0]    in_thermo,
    input  logic                 cfg_invert,
    output logic                 out_valid,
    output logic [BITS_DECO-1:0] out_bin,
    output logic                 out_no_edge,
    output logic                 out_multi
);

    localparam int unsigned NUM_SEG = NUM_FF / SEG_W;
    localparam int unsigned LIMIT   = NUM_FF - GUARD;

    // Elaboration-time parameter checks.
    if (NUM_FF > (1 << BITS_DECO) - 1) begin : g_err_bits
        $error("NUM_FF does not fit in BITS_DECO");
    end
    if ((NUM_FF % SEG_W) != 0) begin : g_err_seg
        $error("NUM_FF must be a multiple of SEG_W");
    end
    if (ZERO_RUN < 1 || ZERO_RUN > 8) begin : g_err_zr
        $error("ZERO_RUN must be 1..8");
    end
    if (GUARD < ZERO_RUN || GUARD >= NUM_FF) begin : g_err_guard
        $error("GUARD must be >= ZERO_RUN and < NUM_FF");
    end
    if (clog2(SEG_W) > SEG_IDX_W) begin : g_err_idx
        $error("SEG_W too wide for seg_result_t index");
    end

    // Stage 1: polarity-corrected column.
    logic              v1_q;
    logic [NUM_FF-1:0] t_q;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            v1_q <= 1'b0;
            t_q  <= '0;
        end else begin
            v1_q <= in_valid;
            if (in_valid) begin
                t_q <= in_thermo ^ {NUM_FF{cfg_invert}};
            end
        end
    end

    // Zero padding above the column feeds the top segment's look-ahead;
    // those taps lie inside the guard band so they never produce a hit.
    logic [NUM_FF+ZERO_RUN-1:0] ext_c;
    assign ext_c = {{ZERO_RUN{1'b0}}, t_q};

    seg_result_t seg_c [NUM_SEG];

    for (genvar s = 0; s < int'(NUM_SEG); s++) begin : g_seg
        tdc_seg_encoder #(
            .SEG_W     (SEG_W),
            .ZERO_RUN  (ZERO_RUN),
            .BITS_DECO (BITS_DECO),
            .LIMIT     (LIMIT)
        ) u_enc (
            .taps  (ext_c[s*SEG_W +: SEG_W+ZERO_RUN]),
            .base  (BITS_DECO'(s*SEG_W)),
            .seg_c (seg_c[s])
        );
    end

    // Stage 2: registered segment results.
    logic        v2_q;
    seg_result_t seg_q [NUM_SEG];

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            v2_q <= 1'b0;
            for (int s = 0; s < int'(NUM_SEG); s++) begin
                seg_q[s] <= '0;
            end
        end else begin
            v2_q <= v1_q;
            for (int s = 0; s < int'(NUM_SEG); s++) begin
                seg_q[s] <= seg_c[s];
            end
        end
    end

    // Stage 3 merge: highest segment with a hit wins. Multiple hits exist if
    // any segment saw two, or a hit segment follows an earlier hit segment.
    logic [BITS_DECO-1:0] bin_c;
    logic                 multi_c;
    logic                 seen_c;

    always_comb begin
        bin_c   = '0;
        multi_c = 1'b0;
        seen_c  = 1'b0;
        for (int s = 0; s < int'(NUM_SEG); s++) begin
            if (seg_q[s].any) begin
                bin_c = BITS_DECO'(s*SEG_W) + BITS_DECO'(seg_q[s].idx)
                      + BITS_DECO'(1);
                if (seen_c || (seg_q[s].cnt == 2'd2)) begin
                    multi_c = 1'b1;
                end
                seen_c = 1'b1;
            end
        end
    end

    // Output registers; values hold between valid results.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            out_valid   <= 1'b0;
            out_bin     <= '0;
            out_no_edge <= 1'b0;
            out_multi   <= 1'b0;
        end else begin
            out_valid <= v2_q;
            if (v2_q) begin
                out_bin     <= bin_c;
                out_no_edge <= !seen_c;
                out_multi   <= multi_c;
            end
        end
    end

endmodule

// File: tb/tb_tdc_thermo_decoder.sv
// Table-driven bench for tdc_thermo_decoder (default parameters).
module tb_tdc_thermo_decoder;

    logic        clk;
    logic        rst_n;
    logic        in_valid;
    logic [63:0] in_thermo;
    logic        cfg_invert;
    logic        out_valid;
    logic [7:0]  out_bin;
    logic        out_no_edge;
    logic        out_multi;

    tdc_thermo_decoder #(
        .NUM_FF    (64),
        .BITS_DECO (8),
        .ZERO_RUN  (4),
        .GUARD     (20),
        .SEG_W     (16)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .in_valid    (in_valid),
        .in_thermo   (in_thermo),
        .cfg_invert  (cfg_invert),
        .out_valid   (out_valid),
        .out_bin     (out_bin),
        .out_no_edge (out_no_edge),
        .out_multi   (out_multi)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic        vld;
        logic        inv;
        logic [63:0] t;
        logic [7:0]  bin;
        logic        ne;
        logic        mu;
    } vec_t;

    vec_t vecs[$];
    int   n_cmp;
    int   n_err;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    // Bits 0..e set (e = -1 gives all zero).
    function automatic logic [63:0] ones(input int e);
        logic [63:0] m;
        m = '0;
        for (int i = 0; i <= e; i++) m[i] = 1'b1;
        return m;
    endfunction

    function automatic logic [63:0] bit1(input int i);
        logic [63:0] m;
        m = '0;
        m[i] = 1'b1;
        return m;
    endfunction

    task automatic add(input logic vld, input logic inv, input logic [63:0] t,
                       input logic [7:0] bin, input logic ne, input logic mu);
        vec_t v;
        v.vld = vld; v.inv = inv; v.t = t; v.bin = bin; v.ne = ne; v.mu = mu;
        vecs.push_back(v);
    endtask

    logic [7:0] hold_bin;
    logic       hold_ne;
    logic       hold_mu;

    initial begin
        n_cmp = 0;
        n_err = 0;
        rst_n      = 1'b0;
        in_valid   = 1'b0;
        in_thermo  = '0;
        cfg_invert = 1'b0;

        // Hand-computed vectors: {valid, invert, column, bin, no_edge, multi}
        add(1, 0, ones(9),                    8'd10, 0, 0); // simple edge
        add(1, 0, ones(9) | bit1(11),         8'd12, 0, 0); // bubble swallowed
        add(1, 0, ones(9) | bit1(20),         8'd21, 0, 1); // two edges
        add(1, 1, ~ones(9),                   8'd10, 0, 0); // inverted line
        add(1, 0, 64'd0,                      8'd0,  1, 0); // all zero
        add(1, 0, ones(50),                   8'd0,  1, 0); // edge in guard
        add(1, 0, ones(43),                   8'd44, 0, 0); // last searchable tap
        add(1, 0, ones(43) | bit1(50),        8'd44, 0, 0); // guard hit ignored
        add(1, 0, ones(47),                   8'd0,  1, 0); // window blocked, edge in guard
        add(0, 0, ones(5),                    8'd0,  0, 0); // gap: outputs hold
        add(1, 0, ~64'd0,                     8'd0,  1, 0); // all ones
        add(1, 0, 64'd1,                      8'd1,  0, 0); // tap 0
        add(1, 0, ones(15),                   8'd16, 0, 0); // look-ahead across segment
        add(1, 0, ones(15) | bit1(18),        8'd19, 0, 0); // blocked by next segment
        add(1, 0, ones(9) | bit1(14),         8'd15, 0, 1); // exactly ZERO_RUN zeros
        add(1, 0, ones(9) | bit1(13),         8'd14, 0, 0); // one zero short
        add(1, 0, ones(3) | bit1(10) | bit1(30), 8'd31, 0, 1); // three hits
        // back-to-back throughput run
        add(1, 0, ones(3),  8'd4,  0, 0);
        add(1, 0, ones(17), 8'd18, 0, 0);
        add(1, 0, ones(31), 8'd32, 0, 0);
        add(1, 0, ones(40), 8'd41, 0, 0);
        add(1, 0, ones(5),  8'd6,  0, 0);
        add(1, 0, ones(27), 8'd28, 0, 0);
        add(1, 0, ones(42), 8'd43, 0, 0);
        add(1, 0, ones(12), 8'd13, 0, 0);
        add(0, 0, 64'd0,    8'd0,  0, 0); // gap after run

        // Reset state
        repeat (2) @(posedge clk);
        #1;
        check("rst_valid",   32'(out_valid),   32'd0);
        check("rst_bin",     32'(out_bin),     32'd0);
        check("rst_no_edge", 32'(out_no_edge), 32'd0);
        check("rst_multi",   32'(out_multi),   32'd0);
        @(negedge clk);
        rst_n = 1'b1;

        hold_bin = '0;
        hold_ne  = 1'b0;
        hold_mu  = 1'b0;

        // Stream the table; result of vector k appears after the capture
        // edge of vector k+2.
        for (int c = 0; c < vecs.size() + 2; c++) begin
            @(negedge clk);
            if (c < vecs.size()) begin
                in_valid   = vecs[c].vld;
                cfg_invert = vecs[c].inv;
                in_thermo  = vecs[c].t;
            end else begin
                in_valid   = 1'b0;
                cfg_invert = 1'b0;
                in_thermo  = '0;
            end
            @(posedge clk);
            #1;
            if (c >= 2) begin
                int k;
                k = c - 2;
                if (vecs[k].vld) begin
                    hold_bin = vecs[k].bin;
                    hold_ne  = vecs[k].ne;
                    hold_mu  = vecs[k].mu;
                end
                check($sformatf("v%0d_valid", k),   32'(out_valid),   32'(vecs[k].vld));
                check($sformatf("v%0d_bin", k),     32'(out_bin),     32'(hold_bin));
                check($sformatf("v%0d_no_edge", k), 32'(out_no_edge), 32'(hold_ne));
                check($sformatf("v%0d_multi", k),   32'(out_multi),   32'(hold_mu));
            end
        end

        // Reset with two captures in flight.
        @(negedge clk);
        in_valid = 1'b1; cfg_invert = 1'b0; in_thermo = ones(9);
        @(negedge clk);
        in_thermo = ones(25);
        @(negedge clk);
        in_valid = 1'b0; in_thermo = '0; rst_n = 1'b0;
        @(posedge clk);
        #1;
        check("mid_rst_valid",   32'(out_valid),   32'd0);
        check("mid_rst_bin",     32'(out_bin),     32'd0);
        check("mid_rst_no_edge", 32'(out_no_edge), 32'd0);
        check("mid_rst_multi",   32'(out_multi),   32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        in_valid = 1'b1; in_thermo = ones(17);
        @(posedge clk);
        #1;
        check("post_rst_c1_valid", 32'(out_valid), 32'd0);
        @(negedge clk);
        in_valid = 1'b0; in_thermo = '0;
        @(posedge clk);
        #1;
        check("post_rst_c2_valid", 32'(out_valid), 32'd0);
        @(posedge clk);
        #1;
        check("post_rst_valid",   32'(out_valid),   32'd1);
        check("post_rst_bin",     32'(out_bin),     32'd18);
        check("post_rst_no_edge", 32'(out_no_edge), 32'd0);
        check("post_rst_multi",   32'(out_multi),   32'd0);
        @(posedge clk);
        #1;
        check("post_rst_strobe_end", 32'(out_valid), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
